// File: rtl/shift_sequencer.sv
// Multi-cycle right-shift controller driving an 8-bit shiftright unit
// one bit per clock, with a start/done handshake toward the ALU.
module shiftright (
    input  logic [7:0] x,
    input  logic       cin,
    input  logic       sel1,
    input  logic       sel0,
    output logic [7:0] f,
    output logic       cout
);

    logic msb;

    always_comb begin
        msb = 1'b0;
        unique case ({sel1, sel0})
            2'b00: msb = 1'b0;
            2'b01: msb = x[0];
            2'b10: msb = cin;
            2'b11: msb = x[7];
            default: msb = 1'b0;
        endcase
    end

    assign f    = {msb, x[7:1]};
    assign cout = x[0];

endmodule

module shift_sequencer #(
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic [7:0]       din,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [7:0]       dout,
    output logic             cout
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;

    logic [7:0]       sh_f;
    logic             sh_cout;

    shiftright u_shr (
        .x    (acc_q),
        .cin  (carry_q),
        .sel1 (mode_q[1]),
        .sel0 (mode_q[0]),
        .f    (sh_f),
        .cout (sh_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= 8'h00;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = din;
                    carry_d = cin;
                    mode_d  = mode;
                    cnt_d   = amt;
                    state_d = (amt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                busy    = 1'b1;
                acc_d   = sh_f;
                carry_d = sh_cout;
                cnt_d   = cnt_q - AMT_W'(1);
                // cnt_q is never 0 here, so the decrement cannot wrap
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dout = acc_q;
    assign cout = carry_q;

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle shift controller sitting directly upstream of the 8-bit `shiftright` unit.
- Captures an operand, a carry-in, a mode and a shift amount, then drives `shiftright` one bit per clock.
- Feeds the shifter's `f`/`cout` back into its own accumulator and carry flag.
- Gives the ALU a start/done handshake for shifts of 0..2^AMT_W-1 positions in any of the four right-shift modes.

Parameters:
- AMT_W, 3: width of shift-amount input and internal down-counter; maximum amount = 2^AMT_W-1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- mode  input  2  {sel1,sel0} for `shiftright`: 00 logical, 01 rotate, 10 rotate-through-carry, 11 arithmetic.
- amt  input  AMT_W  number of single-bit shifts.
- din  input  8  operand.
- cin  input  1  initial carry flag.
- busy  output  1  high while an operation is in progress (SHIFT or DONE).
- done  output  1  one-cycle completion pulse.
- dout  output  8  accumulator contents.
- cout  output  1  carry-flag contents.

Behaviour:
- Reset is asynchronous, active-high. One clock, clk.
- Reset values: state=IDLE, acc=8'h00, carry=0, cnt=0, mode register=00, busy=0, done=0. Therefore dout=8'h00 and cout=0.
- dout = acc register and cout = carry register, continuously. Both hold their last result until the next accepted start.
- Instantiates one `shiftright` with x=acc, cin=carry, sel1/sel0=latched mode. All shift arithmetic comes from that instance.
- States: IDLE, SHIFT, DONE. busy=1 in SHIFT and DONE. done=1 only in DONE.
- IDLE:
  - On a clk edge with start=1: acc<=din, carry<=cin, mode_r<=mode, cnt<=amt.
  - Next state is SHIFT if amt!=0, else DONE.
  - start=0: stay in IDLE.
- SHIFT, each edge:
  - acc<=f, carry<=shifter cout (the pre-shift acc[0]), cnt<=cnt-1.
  - If cnt==1, go to DONE; else stay in SHIFT.
  - Exactly amt shift edges occur.
- DONE: lasts one cycle, then unconditionally returns to IDLE. A start sampled in DONE is ignored.
- Latency:
  - done is high during the cycle following start-edge + amt edges, i.e. done rises amt+1 clocks after the start edge.
  - amt=0: done rises 1 clock after start, with dout=din and cout=cin.
- Input sampling during an operation:
  - start, mode, amt, din and cin are ignored while busy=1.
  - Mode is latched, so mode changes mid-operation have no effect.
- Carry in modes 00, 01 and 11: carry is still updated to the shifted-out bit each step, but does not influence acc.
- Mode 10: acc and carry form a 9-bit right rotation (carry -> acc[7], acc[0] -> carry).
- Reset mid-operation: immediate return to reset values, with no done pulse. A start on the first edge after rst deasserts is accepted.
- Counter: unsigned, never wraps. SHIFT is entered only with cnt>=1.

Test Plan:
- Logical shift: din=8'b10110101, cin=1, mode=00, amt=3, start pulse -> done exactly 4 clocks later; dout=8'b00010110, cout=1; busy high for 4 cycles.
- Rotate: same din, mode=01, amt=3 -> dout=8'b10110110, cout=1.
- Rotate through carry: same din, cin=1, mode=10, amt=2 -> dout=8'b11101101, cout=0; intermediate after first edge acc=8'b11011010, carry=1.
- Arithmetic shift: din=8'b10110101, mode=11, amt=7 -> dout=8'b11111111, cout=0, done 8 clocks after start.
- Zero amount: din=8'h5A, cin=1, amt=0, any mode -> done 1 clock after start, dout=8'h5A, cout=1, no shift performed.
- Control corner cases:
  - start re-pulsed mid-SHIFT with different din/mode -> ignored; result matches the first request.
  - rst asserted mid-SHIFT -> dout=0, cout=0, busy=0, no done pulse.
  - Fresh start after rst deasserts -> completes normally.
